layer1_weight_loader: RTL and testbench

- Upstream feeder for the layer-1 weight storage.
- Accepts a stream of individual layer-1 weights over a valid/ready handshake and packs RELU_NODES consecutive weights into one row.
- Writes each completed row into storage using the storage's own interface: writeEnable, NodeSelect and writeIn.
- Walks NodeSelect from 0 to INPUT_NODES-1 in order, then signals completion.

---
 rtl/layer1_weight_loader_pkg.sv | 18 +
 rtl/layer1_weight_loader_weight_row_packer.sv | 42 ++++
 rtl/layer1_weight_loader.sv | 112 +++++++++++
 tb/tb_layer1_weight_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/layer1_weight_loader_pkg.sv
// rtl/layer1_weight_loader_pkg.sv - shared sizes, flags and state encodings for the layer-1 weight loader
package layer1_weight_loader_pkg;

  localparam int RELU_NODES        = 20;
  localparam int LAYER_1_BIT_WIDTH = 8;
  localparam int INPUT_NODES       = 784;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/layer1_weight_loader_weight_row_packer.sv
// rtl/layer1_weight_loader_weight_row_packer.sv - row buffer, weight counter and row-full flag
module weight_row_packer #(
  parameter int N = 20,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear_i,
  input  logic           load_i,
  input  logic [W-1:0]   weight_i,
  output logic [N*W-1:0] row_next_o,
  output logic           last_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0] buf_q;
  logic [CW-1:0]  count_q;

  // Row as it will look once the presented weight is taken; lets the
  // final transfer and the write capture happen on the same edge.
  always_comb begin
    row_next_o = buf_q;
    row_next_o[count_q*W +: W] = weight_i;
  end

  assign last_o = (count_q == CW'(N - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      buf_q   <= '0;
      count_q <= '0;
    end else if (load_i) begin
      buf_q   <= row_next_o;
      count_q <= last_o ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/layer1_weight_loader.sv
// rtl/layer1_weight_loader.sv - packs streamed layer-1 weights into rows and writes them to storage
module layer1_weight_loader #(
  parameter int RELU_NODES        = layer1_weight_loader_pkg::RELU_NODES,
  parameter int LAYER_1_BIT_WIDTH = layer1_weight_loader_pkg::LAYER_1_BIT_WIDTH,
  parameter int INPUT_NODES       = layer1_weight_loader_pkg::INPUT_NODES
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  start,
  input  logic [LAYER_1_BIT_WIDTH-1:0]          inWeight,
  input  logic                                  inValid,
  output logic                                  inReady,
  output logic                                  writeEnable,
  output logic [9:0]                            NodeSelect,
  output logic [RELU_NODES*LAYER_1_BIT_WIDTH-1:0] writeIn,
  output logic                                  busy,
  output logic                                  done
);

  import layer1_weight_loader_pkg::*;

  localparam int         RW       = RELU_NODES * LAYER_1_BIT_WIDTH;
  localparam logic [9:0] LAST_ROW = 10'(INPUT_NODES - 1);

  state_e        state_q;
  logic          ready_q;
  logic          we_q;
  logic          busy_q;
  logic          done_q;
  logic [9:0]    node_q;
  logic [9:0]    row_idx_q;
  logic [RW-1:0] write_in_q;

  logic          transfer;
  logic          row_last;
  logic          pack_clear;
  logic [RW-1:0] row_next;

  assign transfer   = inValid && ready_q && (state_q == FILL);
  assign pack_clear = (((state_q == IDLE) || (state_q == DONE)) && start) || (state_q == WRITE);

  weight_row_packer #(
    .N(RELU_NODES),
    .W(LAYER_1_BIT_WIDTH)
  ) u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear_i   (pack_clear),
    .load_i    (transfer),
    .weight_i  (inWeight),
    .row_next_o(row_next),
    .last_o    (row_last)
  );

  // NodeSelect is only reloaded on entry to WRITE so it stays put through the
  // strobe and the cycle after; row_idx_q is the running row counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ready_q    <= FALSE;
      we_q       <= FALSE;
      busy_q     <= FALSE;
      done_q     <= FALSE;
      node_q     <= '0;
      row_idx_q  <= '0;
      write_in_q <= '0;
    end else begin
      we_q <= FALSE;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= FILL;
            ready_q   <= TRUE;
            busy_q    <= TRUE;
            done_q    <= FALSE;
            node_q    <= '0;
            row_idx_q <= '0;
          end
        end
        FILL: begin
          if (transfer && row_last) begin
            state_q    <= WRITE;
            ready_q    <= FALSE;
            we_q       <= TRUE;
            write_in_q <= row_next;
            node_q     <= row_idx_q;
          end
        end
        WRITE: begin
          if (row_idx_q == LAST_ROW) begin
            state_q <= DONE;
            busy_q  <= FALSE;
            done_q  <= TRUE;
          end else begin
            state_q   <= FILL;
            ready_q   <= TRUE;
            row_idx_q <= row_idx_q + 10'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inReady     = ready_q;
  assign writeEnable = we_q;
  assign NodeSelect  = node_q;
  assign writeIn     = write_in_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_layer1_weight_loader.sv
// tb/tb_layer1_weight_loader.sv - scoreboard bench for layer1_weight_loader with two-weight rows
module tb_layer1_weight_loader;

  localparam int RN = 2;
  localparam int W  = 8;
  localparam int IN = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  inWeight;
  logic          inValid;
  logic          inReady;
  logic          writeEnable;
  logic [9:0]    NodeSelect;
  logic [RN*W-1:0] writeIn;
  logic          busy;
  logic          done;

  typedef struct {
    logic [9:0]      node;
    logic [RN*W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  layer1_weight_loader #(
    .RELU_NODES(RN),
    .LAYER_1_BIT_WIDTH(W),
    .INPUT_NODES(IN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .inWeight   (inWeight),
    .inValid    (inValid),
    .inReady    (inReady),
    .writeEnable(writeEnable),
    .NodeSelect (NodeSelect),
    .writeIn    (writeIn),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_row(input logic [9:0] node, input logic [RN*W-1:0] data);
    exp_t e;
    e.node = node;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge just after the weight was taken.
  task automatic send(input logic [W-1:0] w, input int gap);
    int n;
    inWeight = w;
    inValid  = 1'b1;
    n = 0;
    while (!inReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", 32'(n), 32'd0);
    @(negedge clk);
    inValid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_reached"}, 32'(n < 500), 32'd1);
    repeat (5) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_inready"}, 32'(inReady), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic full_load(input logic [W-1:0] b, input int gap);
    expect_row(10'd0, {b + 8'h11, b});
    expect_row(10'd1, {b + 8'h33, b + 8'h22});
    expect_row(10'd2, {b + 8'h55, b + 8'h44});
    for (int i = 0; i < 6; i++) send(b + 8'(i * 8'h11), gap);
  endtask

  // Monitor: every strobe must match the head of the scoreboard and hold one more cycle.
  initial begin
    logic [9:0]      h_node;
    logic [RN*W-1:0] h_data;
    logic            h_pend;
    exp_t            e;
    h_pend = 1'b0;
    h_node = '0;
    h_data = '0;
    forever begin
      @(negedge clk);
      if (reset_n && writeEnable) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: node %0d data %h, none expected", NodeSelect, writeIn);
        end else begin
          e = exp_q.pop_front();
          check("write_node", 32'(NodeSelect), 32'(e.node));
          check("write_data", 32'(writeIn), 32'(e.data));
          check("inready_during_write", 32'(inReady), 32'd0);
        end
        h_node = NodeSelect;
        h_data = writeIn;
        h_pend = 1'b1;
      end else if (h_pend) begin
        h_pend = 1'b0;
        if (reset_n) begin
          check("hold_node", 32'(NodeSelect), 32'(h_node));
          check("hold_data", 32'(writeIn), 32'(h_data));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    inValid  = 1'b0;
    inWeight = '0;
    repeat (3) @(negedge clk);
    check("rst_inready", 32'(inReady), 32'd0);
    check("rst_we", 32'(writeEnable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_node", 32'(NodeSelect), 32'd0);
    check("rst_writein", 32'(writeIn), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Back-to-back stream; the weight offered during each strobe must land in slot 0.
    pulse_start();
    check("s1_busy", 32'(busy), 32'd1);
    full_load(8'h11, 0);
    wait_done("s1");

    // Five-cycle gaps between weights; restart from DONE clears done next cycle.
    pulse_start();
    check("s2_done_cleared", 32'(done), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_node_zero", 32'(NodeSelect), 32'd0);
    full_load(8'h11, 5);
    wait_done("s2");

    // start in the middle of row 1 is ignored.
    pulse_start();
    expect_row(10'd0, 16'h0201);
    expect_row(10'd1, 16'h0403);
    expect_row(10'd2, 16'h0605);
    send(8'h01, 0);
    send(8'h02, 0);
    send(8'h03, 1);
    pulse_start();
    send(8'h04, 0);
    send(8'h05, 0);
    send(8'h06, 0);
    wait_done("s4");

    // Asynchronous reset after three weights abandons the load.
    pulse_start();
    expect_row(10'd0, 16'hBBAA);
    send(8'hAA, 0);
    send(8'hBB, 0);
    send(8'hCC, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("s5_async_inready", 32'(inReady), 32'd0);
    check("s5_async_busy", 32'(busy), 32'd0);
    check("s5_async_node", 32'(NodeSelect), 32'd0);
    check("s5_async_writein", 32'(writeIn), 32'd0);
    check("s5_async_we", 32'(writeEnable), 32'd0);
    check("s5_pending_writes", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start();
    full_load(8'hD1, 0);
    wait_done("s5");

    // A second complete load after done must reproduce the first.
    pulse_start();
    check("s6_done_cleared", 32'(done), 32'd0);
    full_load(8'h11, 0);
    wait_done("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
